// File: rtl/grayscale_pkg.sv
// grayscale_pkg: shared definitions for the grayscale pipeline.
//   mode_e                 : output mode encoding (iMode)
//   KR_DEF / KG_DEF / KB_DEF : default luma weights in 1/256 units (BT.601-ish)
package grayscale_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_GRAY   = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_INV    = 2'd3
    } mode_e;

    localparam int KR_DEF = 77;
    localparam int KG_DEF = 150;
    localparam int KB_DEF = 29;

endpackage

// File: rtl/luma_mac.sv
// luma_mac: two-stage weighted luma  Y = (KR*R + KG*G + KB*B + 128) >> 8,
// saturated to DW bits.
//   iCLK, iRST (async, active-low)
//   iValid, iRed/iGreen/iBlue : input pixel
//   oValid, oY                : luma, 2 cycles after iValid
module luma_mac
    import grayscale_pkg::*;
#(
    parameter int DW = 10,
    parameter int KR = KR_DEF,
    parameter int KG = KG_DEF,
    parameter int KB = KB_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iValid,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    output logic          oValid,
    output logic [DW-1:0] oY
);
    // Weights are at most 256 (9 bits), so products fit in DW+9 bits and the
    // three-term sum plus rounding constant fits in DW+11.
    localparam int PRW = DW + 9;
    localparam int SW  = DW + 11;

    if (KR + KG + KB != 256) begin : g_bad_weights
        $error("luma_mac: KR+KG+KB must equal 256");
    end

    logic           s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    logic [PRW-1:0] pr_q, pg_q, pb_q, pr_d, pg_d, pb_d;
    logic [DW-1:0]  y_q, y_d;
    logic [SW-1:0]  sum;
    logic [SW-9:0]  y_full;

    always_comb begin
        s1_vld_d = iValid;
        s2_vld_d = s1_vld_q;
        pr_d     = pr_q;
        pg_d     = pg_q;
        pb_d     = pb_q;
        y_d      = y_q;
        if (iValid) begin
            pr_d = PRW'(iRed)   * PRW'(KR);
            pg_d = PRW'(iGreen) * PRW'(KG);
            pb_d = PRW'(iBlue)  * PRW'(KB);
        end
        sum    = SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + SW'(128);
        y_full = (SW-8)'(sum >> 8);
        if (s1_vld_q) begin
            y_d = (|y_full[SW-9:DW]) ? '1 : y_full[DW-1:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            pr_q     <= '0;
            pg_q     <= '0;
            pb_q     <= '0;
            y_q      <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            pr_q     <= pr_d;
            pg_q     <= pg_d;
            pb_q     <= pb_d;
            y_q      <= y_d;
        end
    end

    assign oValid = s2_vld_q;
    assign oY     = y_q;

endmodule

// File: rtl/grayscale_pipe.sv
// grayscale_pipe: 3-stage pixel pipeline (S1 products, S2 luma, S3 mode/overlay).
//   iCLK, iRST (async, active-low)
//   iValid, iRed/iGreen/iBlue, iMode, iThresh : pixel + per-pixel controls
//   iXposition/iYposition, iXresult/iYresult, iFinished : overlay marker inputs
//   oValid, oRed/oGreen/oBlue : registered result, 3 cycles after iValid
// Optional macro GRAYSCALE_PIPE_OVERLAY_EN adds the red box marker overlay;
// without it the marker inputs are ignored.
module grayscale_pipe
    import grayscale_pkg::*;
#(
    parameter int DW  = 10,
    parameter int PW  = 13,
    parameter int BOX = 20,
    parameter int KR  = KR_DEF,
    parameter int KG  = KG_DEF,
    parameter int KB  = KB_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iValid,
    input  logic [DW-1:0] iRed,
    input  logic [DW-1:0] iGreen,
    input  logic [DW-1:0] iBlue,
    input  logic [1:0]    iMode,
    input  logic [DW-1:0] iThresh,
    input  logic [PW-1:0] iXposition,
    input  logic [PW-1:0] iYposition,
    input  logic [PW-1:0] iXresult,
    input  logic [PW-1:0] iYresult,
    input  logic          iFinished,
    output logic          oValid,
    output logic [DW-1:0] oRed,
    output logic [DW-1:0] oGreen,
    output logic [DW-1:0] oBlue
);
    localparam logic [DW-1:0] PIX_MAX = '1;

    // Side data travelling next to the luma datapath.
    logic          s1_vld_q;
    logic [DW-1:0] s1_r_q, s1_g_q, s1_b_q, s1_thr_q, s1_r_d, s1_g_d, s1_b_d, s1_thr_d;
    mode_e         s1_mode_q, s1_mode_d;
    logic [DW-1:0] s2_r_q, s2_g_q, s2_b_q, s2_thr_q, s2_r_d, s2_g_d, s2_b_d, s2_thr_d;
    mode_e         s2_mode_q, s2_mode_d;
    logic          s2_box_q, s2_box_d;
    logic          box_hit;
    logic          y_vld;
    logic [DW-1:0] y;
    logic          o_vld_q;
    logic [DW-1:0] o_r_q, o_g_q, o_b_q, o_r_d, o_g_d, o_b_d;

    luma_mac #(.DW(DW), .KR(KR), .KG(KG), .KB(KB)) u_luma (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iValid (iValid),
        .iRed   (iRed),
        .iGreen (iGreen),
        .iBlue  (iBlue),
        .oValid (y_vld),
        .oY     (y)
    );

`ifdef GRAYSCALE_PIPE_OVERLAY_EN
    logic [PW-1:0] s1_x_q, s1_y_q, s1_xr_q, s1_yr_q, s1_x_d, s1_y_d, s1_xr_d, s1_yr_d;
    logic          s1_fin_q, s1_fin_d;
    logic [PW:0]   x_hi, y_hi;

    // Window bounds are one bit wider so a corner near the top of the
    // coordinate range does not wrap around to small coordinates.
    always_comb begin
        s1_x_d   = s1_x_q;
        s1_y_d   = s1_y_q;
        s1_xr_d  = s1_xr_q;
        s1_yr_d  = s1_yr_q;
        s1_fin_d = s1_fin_q;
        if (iValid) begin
            s1_x_d   = iXposition;
            s1_y_d   = iYposition;
            s1_xr_d  = iXresult;
            s1_yr_d  = iYresult;
            s1_fin_d = iFinished;
        end
        x_hi    = {1'b0, s1_xr_q} + (PW+1)'(BOX-1);
        y_hi    = {1'b0, s1_yr_q} + (PW+1)'(BOX-1);
        box_hit = s1_fin_q
                  && ({1'b0, s1_x_q} >= {1'b0, s1_xr_q}) && ({1'b0, s1_x_q} <= x_hi)
                  && ({1'b0, s1_y_q} >= {1'b0, s1_yr_q}) && ({1'b0, s1_y_q} <= y_hi);
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_x_q   <= '0;
            s1_y_q   <= '0;
            s1_xr_q  <= '0;
            s1_yr_q  <= '0;
            s1_fin_q <= 1'b0;
        end else begin
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_xr_q  <= s1_xr_d;
            s1_yr_q  <= s1_yr_d;
            s1_fin_q <= s1_fin_d;
        end
    end
`else
    logic unused_overlay;
    assign unused_overlay = ^{iXposition, iYposition, iXresult, iYresult, iFinished};
    assign box_hit        = 1'b0;
`endif

    always_comb begin
        s1_r_d    = s1_r_q;
        s1_g_d    = s1_g_q;
        s1_b_d    = s1_b_q;
        s1_thr_d  = s1_thr_q;
        s1_mode_d = s1_mode_q;
        s2_r_d    = s2_r_q;
        s2_g_d    = s2_g_q;
        s2_b_d    = s2_b_q;
        s2_thr_d  = s2_thr_q;
        s2_mode_d = s2_mode_q;
        s2_box_d  = s2_box_q;
        o_r_d     = o_r_q;
        o_g_d     = o_g_q;
        o_b_d     = o_b_q;
        if (iValid) begin
            s1_r_d    = iRed;
            s1_g_d    = iGreen;
            s1_b_d    = iBlue;
            s1_thr_d  = iThresh;
            s1_mode_d = mode_e'(iMode);
        end
        if (s1_vld_q) begin
            s2_r_d    = s1_r_q;
            s2_g_d    = s1_g_q;
            s2_b_d    = s1_b_q;
            s2_thr_d  = s1_thr_q;
            s2_mode_d = s1_mode_q;
            s2_box_d  = box_hit;
        end
        if (y_vld) begin
            unique case (s2_mode_q)
                MODE_PASS: begin
                    o_r_d = s2_r_q;
                    o_g_d = s2_g_q;
                    o_b_d = s2_b_q;
                end
                MODE_GRAY: begin
                    o_r_d = y;
                    o_g_d = y;
                    o_b_d = y;
                end
                MODE_THRESH: begin
                    o_r_d = (y >= s2_thr_q) ? PIX_MAX : '0;
                    o_g_d = o_r_d;
                    o_b_d = o_r_d;
                end
                default: begin
                    o_r_d = PIX_MAX - y;
                    o_g_d = o_r_d;
                    o_b_d = o_r_d;
                end
            endcase
            // Marker overrides every mode.
            if (s2_box_q) begin
                o_r_d = PIX_MAX;
                o_g_d = '0;
                o_b_d = '0;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s1_vld_q  <= 1'b0;
            s1_r_q    <= '0;
            s1_g_q    <= '0;
            s1_b_q    <= '0;
            s1_thr_q  <= '0;
            s1_mode_q <= MODE_PASS;
            s2_r_q    <= '0;
            s2_g_q    <= '0;
            s2_b_q    <= '0;
            s2_thr_q  <= '0;
            s2_mode_q <= MODE_PASS;
            s2_box_q  <= 1'b0;
            o_vld_q   <= 1'b0;
            o_r_q     <= '0;
            o_g_q     <= '0;
            o_b_q     <= '0;
        end else begin
            s1_vld_q  <= iValid;
            s1_r_q    <= s1_r_d;
            s1_g_q    <= s1_g_d;
            s1_b_q    <= s1_b_d;
            s1_thr_q  <= s1_thr_d;
            s1_mode_q <= s1_mode_d;
            s2_r_q    <= s2_r_d;
            s2_g_q    <= s2_g_d;
            s2_b_q    <= s2_b_d;
            s2_thr_q  <= s2_thr_d;
            s2_mode_q <= s2_mode_d;
            s2_box_q  <= s2_box_d;
            o_vld_q   <= y_vld;
            o_r_q     <= o_r_d;
            o_g_q     <= o_g_d;
            o_b_q     <= o_b_d;
        end
    end

    assign oValid = o_vld_q;
    assign oRed   = o_r_q;
    assign oGreen = o_g_q;
    assign oBlue  = o_b_q;

endmodule

// File: tb/tb_grayscale_pipe.sv
// tb_grayscale_pipe: randomized + directed stimulus, scoreboard queue filled by
// the driver from a reference model, drained by an independent monitor.
module tb_grayscale_pipe;
    localparam int DW  = 10;
    localparam int PW  = 13;
    localparam int BOX = 20;
    localparam int KR  = 77;
    localparam int KG  = 150;
    localparam int KB  = 29;
    localparam int MAXV = (1 << DW) - 1;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iValid = 1'b0;
    logic [DW-1:0] iRed = '0, iGreen = '0, iBlue = '0, iThresh = '0;
    logic [1:0]    iMode = '0;
    logic [PW-1:0] iXposition = '0, iYposition = '0, iXresult = '0, iYresult = '0;
    logic          iFinished = 1'b0;
    logic          oValid;
    logic [DW-1:0] oRed, oGreen, oBlue;

    grayscale_pipe #(.DW(DW), .PW(PW), .BOX(BOX), .KR(KR), .KG(KG), .KB(KB)) dut (
        .iCLK(iCLK), .iRST(iRST), .iValid(iValid),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .iMode(iMode), .iThresh(iThresh),
        .iXposition(iXposition), .iYposition(iYposition),
        .iXresult(iXresult), .iYresult(iYresult), .iFinished(iFinished),
        .oValid(oValid), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int r, g, b;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   last_r = 0, last_g = 0, last_b = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the rules: weighted luma, mode table,
    // then the marker box on top.
    function automatic exp_t model(input int r, g, b, mode, thr, x, y, xr, yr, fin);
        exp_t e;
        int yv;
        yv = (KR * r + KG * g + KB * b + 128) / 256;
        if (yv > MAXV) yv = MAXV;
        case (mode)
            0: begin e.r = r; e.g = g; e.b = b; end
            1: begin e.r = yv; e.g = yv; e.b = yv; end
            2: begin e.r = (yv >= thr) ? MAXV : 0; e.g = e.r; e.b = e.r; end
            default: begin e.r = MAXV - yv; e.g = e.r; e.b = e.r; end
        endcase
`ifdef GRAYSCALE_PIPE_OVERLAY_EN
        if (fin != 0 && x >= xr && x <= xr + BOX - 1 && y >= yr && y <= yr + BOX - 1) begin
            e.r = MAXV; e.g = 0; e.b = 0;
        end
`endif
        e.due = 0;
        return e;
    endfunction

    // One cycle of stimulus; a valid pixel pushes its expected result.
    task automatic drive(input int v, r, g, b, mode, thr, x, y, xr, yr, fin);
        exp_t e;
        @(posedge iCLK);
        #1;
        iValid     = (v != 0);
        iRed       = DW'(r);
        iGreen     = DW'(g);
        iBlue      = DW'(b);
        iMode      = 2'(mode);
        iThresh    = DW'(thr);
        iXposition = PW'(x);
        iYposition = PW'(y);
        iXresult   = PW'(xr);
        iYresult   = PW'(yr);
        iFinished  = (fin != 0);
        if (v != 0) begin
            e = model(r, g, b, mode, thr, x, y, xr, yr, fin);
            e.due = cyc + 3;
            sb.push_back(e);
        end
    endtask

    task automatic pix(input int r, g, b, mode, thr);
        drive(1, r, g, b, mode, thr, 0, 0, 0, 0, 0);
    endtask

    task automatic ovl(input int x, y, xr, yr, fin, mode);
        drive(1, 300, 500, 700, mode, 0, x, y, xr, yr, fin);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: pops on every output beat, checks latency and data; between
    // beats the outputs must hold; under reset they must be zero.
    always @(negedge iCLK) begin
        if (!iRST) begin
            check("rst_valid", int'(oValid), 0);
            check("rst_rgb", int'({oRed, oGreen, oBlue}), 0);
            last_r = 0; last_g = 0; last_b = 0;
        end else if (oValid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", cyc, e.due);
                check("red", int'(oRed), e.r);
                check("green", int'(oGreen), e.g);
                check("blue", int'(oBlue), e.b);
                last_r = e.r; last_g = e.g; last_b = e.b;
            end
        end else begin
            check("hold_red", int'(oRed), last_r);
            check("hold_green", int'(oGreen), last_g);
            check("hold_blue", int'(oBlue), last_b);
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1;

        // Directed luma / mode cases.
        pix(1023, 1023, 1023, 1, 0);
        pix(1023, 0, 0, 1, 0);
        pix(1023, 0, 0, 3, 0);
        pix(600, 600, 600, 2, 512);
        pix(400, 400, 400, 2, 512);
        pix(123, 456, 789, 0, 0);
        pix(600, 600, 600, 1, 512);
        pix(600, 600, 600, 2, 512);
        pix(600, 600, 600, 3, 512);
        pix(600, 600, 600, 0, 512);
        idle();

        // Marker window edges, disabled marker and near-top-of-range corner.
        ovl(100, 50, 100, 50, 1, 1);
        ovl(119, 69, 100, 50, 1, 2);
        ovl(120, 50, 100, 50, 1, 1);
        ovl(100, 70, 100, 50, 1, 3);
        ovl(99, 50, 100, 50, 1, 0);
        ovl(100, 50, 100, 50, 0, 1);
        ovl(8191, 50, 8190, 50, 1, 1);
        ovl(0, 50, 8190, 50, 1, 1);
        repeat (2) idle();

        // Randomized stream around a marker.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(3) != 0) ? 1 : 0,
                  $urandom_range(MAXV), $urandom_range(MAXV), $urandom_range(MAXV),
                  $urandom_range(3), $urandom_range(MAXV),
                  $urandom_range(130, 90), $urandom_range(80, 40),
                  100, 50, $urandom_range(1));
        end
        repeat (4) idle();

        // Mid-stream reset: in-flight pixels are dropped.
        for (int i = 0; i < 5; i++) pix(100 * i, 200, 300, 1, 0);
        #2 iRST = 1'b0;
        #1;
        check("async_rst_valid", int'(oValid), 0);
        check("async_rst_rgb", int'({oRed, oGreen, oBlue}), 0);
        sb.delete();
        iValid = 1'b0;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b1;
        idle();
        pix(1023, 0, 0, 3, 0);
        repeat (5) idle();

        // Drain with a bounded wait.
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge iCLK);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        @(negedge iCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grayscale_pipe.md
GRAYSCALE_PIPE -- requirements
Module: grayscale_pipe

Interface
REQ-001 SHALL have parameter DW, default 10, colour channel width in bits.
REQ-002 SHALL have parameter PW, default 13, pixel coordinate width in bits.
REQ-003 SHALL have parameter BOX, default 20, overlay marker edge length in pixels.
REQ-004 SHALL have parameters KR, KG, KB, defaults 77, 150, 29, luma weights in 1/256 units; KR+KG+KB SHALL equal 256 (elaboration check).
REQ-005 SHALL have port iCLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port iRST  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port iValid  input  1  input pixel qualifier.
REQ-008 SHALL have ports iRed, iGreen, iBlue  input  DW each  input pixel.
REQ-009 SHALL have port iMode  input  2  0 passthrough, 1 gray, 2 threshold, 3 inverted gray.
REQ-010 SHALL have port iThresh  input  DW  threshold level for mode 2.
REQ-011 SHALL have ports iXposition, iYposition  input  PW each  coordinates of the current pixel.
REQ-012 SHALL have ports iXresult, iYresult  input  PW each  top-left corner of the overlay marker.
REQ-013 SHALL have port iFinished  input  1  marker coordinates valid.
REQ-014 SHALL have port oValid  output  1  output pixel qualifier.
REQ-015 SHALL have ports oRed, oGreen, oBlue  output  DW each  processed pixel, registered.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 weighted products, S2 sum and normalise, S3 mode select and overlay; latency exactly 3 iCLK cycles from iValid to oValid.
REQ-017 SHALL accept one pixel per cycle, no backpressure; oValid SHALL equal iValid delayed by 3 cycles.
REQ-018 SHALL capture iMode, iThresh, coordinates, iXresult, iYresult and iFinished in S1 alongside the pixel, so mode changes take effect per pixel, never mid-pixel.
REQ-019 SHALL compute Y = (KR*R + KG*G + KB*B + 128) >> 8 at full product width, saturated to 2^DW-1.
REQ-020 Mode 0 SHALL output the delayed input RGB unchanged; mode 1 SHALL output Y on all channels; mode 2 SHALL output 2^DW-1 on all channels when Y >= iThresh, else 0; mode 3 SHALL output (2^DW-1)-Y on all channels.
REQ-021 Overlay window SHALL be iXresult <= X <= iXresult+BOX-1 and iYresult <= Y <= iYresult+BOX-1, compared at PW+1 bits (no wrap-around when the corner is near 2^PW-1).
REQ-022 Inside the window with captured iFinished=1, output SHALL be oRed=2^DW-1, oGreen=0, oBlue=0, overriding every mode.
REQ-023 S1-S3 data registers SHALL load only when their stage valid bit is 1; when oValid=0, outputs SHALL hold their last value.

Reset
REQ-024 iRST low SHALL immediately clear all stage valid bits and drive oValid=0, oRed=oGreen=oBlue=0.
REQ-025 A reset mid-stream SHALL discard all in-flight pixels; the first pixel accepted after release SHALL appear 3 cycles later.

Configuration
REQ-026 With macro GRAYSCALE_PIPE_OVERLAY_EN defined, overlay logic per REQ-021/022 SHALL be present.
REQ-027 Without GRAYSCALE_PIPE_OVERLAY_EN, iXresult, iYresult, iFinished, iXposition, iYposition SHALL be ignored and output SHALL depend on mode only; ports and latency SHALL be unchanged.

Structure
REQ-028 Shared package grayscale_pkg SHALL hold the mode encoding enum and default KR/KG/KB constants.
REQ-029 S1-S2 luma arithmetic SHALL be the sub-module luma_mac (parameters DW, KR, KG, KB; 2-cycle latency, valid in/out).

Verification
REQ-030 Mode 1, R=G=B=1023 valid one cycle -> 3 cycles later oValid=1, all outputs 1023.
REQ-031 Mode 1, R=1023, G=0, B=0 -> all outputs 308; mode 3 same pixel -> 715.
REQ-032 Mode 2, iThresh=512, R=G=B=600 -> 1023 all; R=G=B=400 -> 0 all; back-to-back pixels with alternating modes -> each output matches its own mode.
REQ-033 Overlay enabled, iXresult=100, iYresult=50, iFinished=1: pixel (100,50) and (119,69) -> 1023/0/0; (120,50) -> normal mode output; iFinished=0 at (100,50) -> normal output; iXresult=8190 -> pixel (8191,50) overlays, (0,50) does not.
REQ-034 Stream 10 valid pixels, assert iRST low at pixel 5 -> outputs 0 and oValid 0 immediately; after release no stale pixel emerges; new pixel appears after exactly 3 cycles.
